// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encoding and port indices for the memory arbiter.
package mem_arbiter_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;
  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_AUX = 1'b1;
  localparam int CNT_W = 4;
endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin grant; a tie goes to the port that did not win last.
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic grant
);
  assign valid = req0 | req1;
  assign grant = (req0 & req1) ? ~last_grant : (req1 ? PORT_AUX : PORT_CORE);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency memory between the core (port 0) and aux (port 1) requesters.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_stall,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);
  logic [1:0] state, nxt;
  logic [CNT_W-1:0] cnt;
  logic owner, last_grant, we_q, pick_valid, pick, done;
  rr_pick2 u_pick (
    .req0(p0_req),
    .req1(p1_req),
    .last_grant(last_grant),
    .valid(pick_valid),
    .grant(pick)
  );
  always_comb
    nxt = state == IDLE  ? (pick_valid ? ISSUE : IDLE) :
          state == ISSUE ? (LAT > 1 ? WAIT : RESP) :
          state == WAIT  ? (cnt == CNT_W'(1) ? RESP : WAIT) : IDLE;
  // ack and read data are registered on the edge into RESP, so both are visible during RESP
  assign done = (state != RESP) && (nxt == RESP);
  assign mem_en = state == ISSUE;
  assign mem_we = we_q;
  assign p0_stall = p0_req & ~p0_ack;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      owner <= PORT_CORE;
      last_grant <= PORT_AUX;
      we_q <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      p0_rdata <= '0;
      p1_rdata <= '0;
    end else begin
      state <= nxt;
      cnt <= state == ISSUE ? CNT_INIT : state == WAIT ? cnt - CNT_W'(1) : cnt;
      p0_ack <= done & (owner == PORT_CORE);
      p1_ack <= done & (owner == PORT_AUX);
      if (done & ~we_q & (owner == PORT_CORE)) p0_rdata <= mem_rdata;
      if (done & ~we_q & (owner == PORT_AUX)) p1_rdata <= mem_rdata;
      if (state == IDLE && pick_valid) begin
        owner <= pick;
        last_grant <= pick;
        we_q <= pick ? p1_we : p0_we;
        mem_addr <= pick ? p1_addr : p0_addr;
        mem_wdata <= pick ? p1_wdata : p0_wdata;
      end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration, timing and reset on LAT=2 and LAT=1 instances.
module tb_mem_arbiter;
  logic clk = 1'b0, reset = 1'b0;
  logic p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [31:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
  logic p0_ack, p0_stall, p1_ack, mem_en, mem_we;
  logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_rdata;
  logic a_p0_ack, a_p0_stall, a_p1_ack, a_mem_en, a_mem_we;
  logic [31:0] a_p0_rdata, a_p1_rdata, a_mem_addr, a_mem_wdata;
  logic [31:0] a_mem_rdata = 32'hBAD0BAD0;
  logic mv = 1'b0;
  logic [31:0] md = '0;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(2)) u_dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_stall(p0_stall),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(a_p0_ack), .p0_rdata(a_p0_rdata), .p0_stall(a_p0_stall),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(a_p1_ack), .p1_rdata(a_p1_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata)
  );
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a == 32'h10 ? 32'hE3A01005 : {a[15:0], ~a[15:0]};
  endfunction
  // LAT=2 memory: read data is valid only in the single cycle after the mem_en cycle
  always @(posedge clk) begin
    mv <= mem_en & ~mem_we;
    md <= mem_val(mem_addr);
  end
  assign mem_rdata = mv ? md : 32'hBAD0BAD0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic mid();
    @(negedge clk);
  endtask
  task automatic do_reset();
    reset = 1'b0;
    {p0_req, p0_we, p1_req, p1_we} = '0;
    {p0_addr, p0_wdata, p1_addr, p1_wdata} = '0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask
  initial begin
    do_reset();
    mid();
    check("rst_mem_en", mem_en, 0);
    check("rst_acks", {p0_ack, p1_ack}, 0);
    check("rst_rdata", p0_rdata | p1_rdata, 0);
    check("rst_mem_bus", {mem_we, mem_addr | mem_wdata}, 0);
    // core read, LAT=2
    cyc(); p0_req = 1; p0_addr = 32'h10; mid();
    check("rd_c0_stall", p0_stall, 1);
    check("rd_c0_en", mem_en, 0);
    cyc(); mid();
    check("rd_c1_en", mem_en, 1);
    check("rd_c1_addr", mem_addr, 32'h10);
    check("rd_c1_we", mem_we, 0);
    check("rd_c1_stall", p0_stall, 1);
    cyc(); mid();
    check("rd_c2_en", mem_en, 0);
    check("rd_c2_ack", p0_ack, 0);
    check("rd_c2_stall", p0_stall, 1);
    cyc(); mid();
    check("rd_c3_ack", p0_ack, 1);
    check("rd_c3_rdata", p0_rdata, 32'hE3A01005);
    check("rd_c3_stall", p0_stall, 0);
    check("rd_c3_p1ack", p1_ack, 0);
    cyc(); p0_req = 0; mid();
    check("rd_c4_ack", p0_ack, 0);
    check("rd_c4_rdata_hold", p0_rdata, 32'hE3A01005);
    cyc(); mid();
    check("rd_c5_no_reissue", mem_en, 0);
    // aux write, LAT=1
    do_reset();
    cyc(); p1_req = 1; p1_we = 1; p1_addr = 32'h20; p1_wdata = 32'hDEADBEEF; mid();
    check("wr_c0_en", a_mem_en, 0);
    cyc(); mid();
    check("wr_c1_en", a_mem_en, 1);
    check("wr_c1_we", a_mem_we, 1);
    check("wr_c1_addr", a_mem_addr, 32'h20);
    check("wr_c1_wdata", a_mem_wdata, 32'hDEADBEEF);
    check("wr_c1_ack", a_p1_ack, 0);
    cyc(); mid();
    check("wr_c2_ack", a_p1_ack, 1);
    check("wr_c2_p0ack", a_p0_ack, 0);
    check("wr_c2_en", a_mem_en, 0);
    check("wr_c2_rdata", a_p1_rdata, 0);
    cyc(); p1_req = 0; p1_we = 0; mid();
    check("wr_c3_ack", a_p1_ack, 0);
    check("wr_c3_en", a_mem_en, 0);
    check("wr_c3_addr_hold", a_mem_addr, 32'h20);
    // simultaneous requests alternate p0, p1, p0, p1
    do_reset();
    cyc(); p0_req = 1; p1_req = 1; p0_addr = 32'h100; p1_addr = 32'h200;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) cyc();
      mid();
      check($sformatf("rr_c%0d_p0ack", c), p0_ack, (c == 3 || c == 11) ? 1 : 0);
      check($sformatf("rr_c%0d_p1ack", c), p1_ack, (c == 7 || c == 15) ? 1 : 0);
      check($sformatf("rr_c%0d_en", c), mem_en, (c % 4 == 1) ? 1 : 0);
      if (c % 4 == 1)
        check($sformatf("rr_c%0d_addr", c), mem_addr, (c == 1 || c == 9) ? 32'h100 : 32'h200);
      if (c == 3) check("rr_p0_rdata", p0_rdata, 32'h0100FEFF);
      if (c == 7) check("rr_p1_rdata", p1_rdata, 32'h0200FDFF);
    end
    // late p1 request during the ISSUE cycle of a p0 read
    do_reset();
    cyc(); p0_req = 1; p0_addr = 32'h10; p1_addr = 32'h30;
    cyc(); p1_req = 1; mid();
    check("late_c1_addr", mem_addr, 32'h10);
    cyc(); cyc(); mid();
    check("late_c3_p0ack", p0_ack, 1);
    check("late_c3_p1ack", p1_ack, 0);
    check("late_c3_rdata", p0_rdata, 32'hE3A01005);
    cyc(); p0_req = 0; cyc(); mid();
    check("late_c5_en", mem_en, 1);
    check("late_c5_addr", mem_addr, 32'h30);
    cyc(); cyc(); mid();
    check("late_c7_p1ack", p1_ack, 1);
    check("late_c7_p1rdata", p1_rdata, 32'h0030FFCF);
    check("late_c7_p0rdata", p0_rdata, 32'hE3A01005);
    check("late_c7_p0ack", p0_ack, 0);
    cyc(); p1_req = 0;
    // reset in WAIT abandons the access; the first tie afterwards goes to p0
    do_reset();
    cyc(); p0_req = 1; p0_addr = 32'h10;
    cyc(); cyc(); reset = 0; p0_req = 0; #1;
    check("arst_en", mem_en, 0);
    check("arst_acks", {p0_ack, p1_ack}, 0);
    check("arst_addr", mem_addr, 0);
    @(posedge clk); #1 reset = 1;
    cyc(); p0_req = 1; p1_req = 1; p0_addr = 32'h100; p1_addr = 32'h200; mid();
    check("arst_c0_acks", {p0_ack, p1_ack}, 0);
    cyc(); mid();
    check("arst_c1_addr", mem_addr, 32'h100);
    cyc(); cyc(); mid();
    check("arst_c3_p0ack", p0_ack, 1);
    check("arst_c3_p1ack", p1_ack, 0);
    cyc(); p0_req = 0; p1_req = 0;
    // req held past ack is taken as a second access to the same address
    do_reset();
    cyc(); p0_req = 1; p0_addr = 32'h40;
    cyc(); cyc(); cyc(); mid();
    check("hold_c3_ack", p0_ack, 1);
    check("hold_c3_rdata", p0_rdata, 32'h0040FFBF);
    cyc(); mid();
    check("hold_c4_ack", p0_ack, 0);
    cyc(); mid();
    check("hold_c5_proto_reissue", mem_en, 1);
    check("hold_c5_addr", mem_addr, 32'h40);
    cyc(); cyc(); mid();
    check("hold_c7_ack", p0_ack, 1);
    cyc(); p0_req = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
